frame_shift_reg: RTL and testbench

Parametrised frame shifter for the UART data path; successor to the plain load/shift register. Loads a word, shifts a run-time-selectable number of bits (1..D_BIT) on baud-tick enables, LSB-first or MSB-first, and provides:
- serial-out bit, for transmit;
- right-justified received word;
- running parity of shifted-in bits;
- busy/done handshake.

Used by both the transmitter (parallel-to-serial) and the receiver (serial-to-parallel).

---
 rtl/uart_pkg.sv | 16 +
 rtl/register.sv | 20 ++
 rtl/frame_shift_reg.sv | 109 ++++++++++
 tb/tb_frame_shift_reg.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART data-path definitions: frame shifter FSM encoding, shift
// direction constants and the bit-counter width helper.
package uart_pkg;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACTIVE = 1'b1;

   localparam logic DIR_LSB = 1'b0;
   localparam logic DIR_MSB = 1'b1;

   // Counter must hold every value 0..d_bit inclusive.
   function automatic int cnt_width(input int d_bit);
      return $clog2(d_bit + 1);
   endfunction

endpackage

// File: rtl/register.sv
// Enabled D-register with synchronous active-high clear; the caller supplies
// the next-state mux.
module register #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its inputs.
   always_ff @(posedge clk) begin
      if (rst)     q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/frame_shift_reg.sv
// Frame shifter for the UART data path: loads a word, shifts 1..D_BIT bits on
// baud ticks in either direction, and reports serial out, aligned word, parity.
module frame_shift_reg
   import uart_pkg::*;
#(
   parameter int D_BIT = 8,
   parameter int CNT_W = cnt_width(D_BIT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [D_BIT-1:0] d_reg,
   input  logic [CNT_W-1:0] len,
   input  logic             dir,
   input  logic             d,
   output logic [D_BIT-1:0] q,
   output logic [D_BIT-1:0] q_align,
   output logic             s_out,
   output logic             parity,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(D_BIT);

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] len_clamp;
   logic             dir_r;
   logic             shift;
   logic             last;
   logic             q_en;
   logic [D_BIT-1:0] q_next;

   assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
   // Load always wins over a coincident baud tick.
   assign shift     = (state == ACTIVE) && en && !load;
   assign last      = shift && (cnt == CNT_W'(1));
   assign q_en      = load || shift;
   assign busy      = (state == ACTIVE);

   // NOTE: q_next gets a default before any branch, so no latch is inferred.
   always_comb begin
      q_next = d_reg;
      if (!load) begin
         if (dir_r == DIR_MSB) q_next = {q[D_BIT-2:0], d};
         else                  q_next = {d, q[D_BIT-1:1]};
      end
   end

   register #(.W(D_BIT)) u_q_reg (
      .clk (clk),
      .rst (rst),
      .en  (q_en),
      .d   (q_next),
      .q   (q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         len_r  <= LEN_MAX;
         dir_r  <= DIR_LSB;
         parity <= 1'b0;
         done   <= 1'b0;
      end else begin
         // done is a single-cycle pulse unless re-armed below.
         done <= 1'b0;
         if (load) begin
            len_r  <= len_clamp;
            dir_r  <= dir;
            cnt    <= len_clamp;
            parity <= 1'b0;
            if (len_clamp != '0) begin
               state <= ACTIVE;
            end else begin
               state <= IDLE;
               done  <= 1'b1;
            end
         end else if (shift) begin
            cnt    <= cnt - CNT_W'(1);
            parity <= parity ^ d;
            if (last) begin
               state <= IDLE;
               done  <= 1'b1;
            end
         end
      end
   end

   // MSB-first frames emit from the top of the active window, q[len_r-1].
   always_comb begin
      s_out = q[0];
      if (dir_r == DIR_MSB) begin
         for (int i = 0; i < D_BIT; i++) begin
            if (int'(len_r) == i + 1) s_out = q[i];
         end
      end
   end

   always_comb begin
      if (dir_r == DIR_MSB) q_align = q & ~({D_BIT{1'b1}} << len_r);
      else                  q_align = q >> (LEN_MAX - len_r);
   end

endmodule

// File: tb/tb_frame_shift_reg.sv
// Scoreboard bench for frame_shift_reg: a driver issues frames and queues the
// expected serial bits and frame results; a monitor checks them as they appear.
module tb_frame_shift_reg;

   localparam int D  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          load = 1'b0;
   logic [D-1:0]  d_reg = '0;
   logic [CW-1:0] len = '0;
   logic          dir = 1'b0;
   logic          d = 1'b0;
   logic [D-1:0]  q;
   logic [D-1:0]  q_align;
   logic          s_out;
   logic          parity;
   logic          busy;
   logic          done;

   typedef struct {
      logic [D-1:0] q;
      logic [D-1:0] q_align;
      logic         parity;
      int           shifts;
   } frame_t;

   frame_t exp_q[$];
   bit     tx_q[$];
   int     n_checks = 0;
   int     n_pass   = 0;

   frame_shift_reg #(.D_BIT(D), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .d_reg   (d_reg),
      .len     (len),
      .dir     (dir),
      .d       (d),
      .q       (q),
      .q_align (q_align),
      .s_out   (s_out),
      .parity  (parity),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Frame result from the serial rules: first bit received lands at the low
   // end for LSB-first and at the top of the window for MSB-first.
   function automatic frame_t model(input logic [D-1:0] w, input int lc, input logic dr,
                                    input logic [D-1:0] inb);
      frame_t m;
      int     recv = 0;
      int     full;
      bit     par = 0;
      for (int i = 0; i < lc; i++) begin
         par ^= inb[i];
         if (dr) recv |= int'(inb[i]) << (lc - 1 - i);
         else    recv |= int'(inb[i]) << i;
      end
      if (dr) full = (int'(w) << lc) | recv;
      else    full = (int'(w) >> lc) | (recv << (D - lc));
      m.q       = full[D-1:0];
      m.q_align = recv[D-1:0];
      m.parity  = par;
      m.shifts  = lc;
      return m;
   endfunction

   // gap < 0 picks random idle cycles between ticks; abort >= 0 stops after
   // that many shifts and expects no done for the frame.
   task automatic run_frame(input logic [D-1:0] w, input int l, input logic dr,
                            input logic [D-1:0] inb, input int gap, input int abort,
                            input bit en_on_load);
      int lc = (l > D) ? D : l;
      int n  = (abort >= 0) ? abort : lc;
      for (int i = 0; i < n; i++) tx_q.push_back(dr ? w[lc-1-i] : w[i]);
      if (abort < 0) exp_q.push_back(model(w, lc, dr, inb));
      load  = 1'b1;
      d_reg = w;
      len   = CW'(l);
      dir   = dr;
      en    = en_on_load;
      d     = 1'($urandom_range(0, 1));
      tick();
      load = 1'b0;
      en   = 1'b0;
      for (int i = 0; i < n; i++) begin
         int g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
         repeat (g) begin
            d = 1'($urandom_range(0, 1));
            tick();
         end
         en = 1'b1;
         d  = inb[i];
         tick();
         en = 1'b0;
      end
      if (abort < 0) repeat (2) tick();
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   initial begin
      frame_t       e;
      bit           b;
      logic [D-1:0] prev_q = '0;
      bit           prev_hold = 0;
      int           shifts = 0;
      forever begin
         @(negedge clk);
         if (done) begin
            if (exp_q.size() == 0) begin
               check("done_spurious", done, 0);
            end else begin
               e = exp_q.pop_front();
               check("frame_q", q, e.q);
               check("frame_q_align", q_align, e.q_align);
               check("frame_parity", parity, e.parity);
               check("frame_shifts", shifts, e.shifts);
               check("frame_busy_low", busy, 0);
            end
         end
         if (prev_hold) check("hold_q", q, prev_q);
         if (rst || load) begin
            shifts = 0;
         end else if (busy && en) begin
            if (tx_q.size() == 0) begin
               check("shift_spurious", busy, 0);
            end else begin
               b = tx_q.pop_front();
               check("s_out", s_out, b);
            end
            shifts++;
         end
         prev_hold = !rst && !load && !(busy && en);
         prev_q    = q;
      end
   end

   initial begin
      repeat (3) tick();
      check("rst_q", q, 0);
      check("rst_q_align", q_align, 0);
      check("rst_s_out", s_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_parity", parity, 0);
      rst = 1'b0;
      tick();

      run_frame(8'hA5, 8, 1'b0, 8'hFF, 0, -1, 1'b0);
      run_frame(8'h00, 8, 1'b0, 8'h3C, 15, -1, 1'b0);
      run_frame(8'h13, 5, 1'b1, 8'h0A, -1, -1, 1'b0);
      run_frame(8'($urandom), 5, 1'b0, 8'h15, -1, -1, 1'b0);

      run_frame(8'h5A, 8, 1'b0, 8'($urandom), -1, 3, 1'b0);
      run_frame(8'h0F, 8, 1'b0, 8'($urandom), -1, -1, 1'b1);

      run_frame(8'($urandom), 0, 1'($urandom_range(0, 1)), 8'h00, -1, -1, 1'b0);
      run_frame(8'($urandom), 12, 1'b1, 8'($urandom), -1, -1, 1'b0);

      run_frame(8'h96, 8, 1'b0, 8'($urandom), 1, 4, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_q", q, 0);
      check("mid_rst_s_out", s_out, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_parity", parity, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_q_align", q_align, 0);
      repeat (5) begin
         en = 1'b1;
         d  = 1'b1;
         tick();
         en = 1'b0;
         tick();
      end
      check("post_rst_q", q, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_parity", parity, 0);

      for (int k = 0; k < 40; k++) begin
         run_frame(8'($urandom), int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                   8'($urandom), -1, -1, 1'($urandom_range(0, 1)));
      end

      repeat (3) tick();
      check("frames_pending", exp_q.size(), 0);
      check("txbits_pending", tx_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
